// File: rtl/dot_pkg.sv
// Shared constants and types for the 8-element signed dot-product accelerator.
package dot_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;
  localparam int N_ELEM = 8;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/dot_mac_unit.sv
// Registered signed multiply-accumulate: one full-width product is added
// per enabled clock; clr restarts the sum from zero.
module dot_mac_unit
  import dot_pkg::*;
#(
  parameter int SUM_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [SUM_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [SUM_W-1:0]    prod_ext;
  logic signed [SUM_W-1:0]    acc_d;
  logic signed [SUM_W-1:0]    acc_q;

  // Product, sign-extended to the accumulator width, and next sum
  always_comb begin
    prod     = a * b;
    prod_ext = SUM_W'(prod);
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // Accumulator register, cleared by the active-low asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_accel.sv
// Sequential 8-element signed dot-product accelerator.
// start latches both operand vectors; eight MAC cycles follow, then one
// cycle to publish the sum, so done rises after the 9th edge past start.
// rst is asynchronous and active-low.
// Optional build macro DOT_SATURATE_EN: 3 guard bits in the accumulator and
// the published result is clamped to the signed 64-bit range instead of
// wrapping.
module dot_product_accel
  import dot_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  input  logic signed [DATA_W-1:0] a0,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] a2,
  input  logic signed [DATA_W-1:0] a3,
  input  logic signed [DATA_W-1:0] a4,
  input  logic signed [DATA_W-1:0] a5,
  input  logic signed [DATA_W-1:0] a6,
  input  logic signed [DATA_W-1:0] a7,
  input  logic signed [DATA_W-1:0] b0,
  input  logic signed [DATA_W-1:0] b1,
  input  logic signed [DATA_W-1:0] b2,
  input  logic signed [DATA_W-1:0] b3,
  input  logic signed [DATA_W-1:0] b4,
  input  logic signed [DATA_W-1:0] b5,
  input  logic signed [DATA_W-1:0] b6,
  input  logic signed [DATA_W-1:0] b7,
  output logic signed [ACC_W-1:0]  result
);

`ifdef DOT_SATURATE_EN
  localparam int SUM_W = ACC_W + 3;

  // Clamp the wide sum into the signed ACC_W range
  function automatic acc_t sat_acc(input logic signed [SUM_W-1:0] s);
    logic [SUM_W-ACC_W:0] top;
    top = s[SUM_W-1:ACC_W-1];
    if ((&top) || !(|top)) begin
      return s[ACC_W-1:0];
    end else if (s[SUM_W-1]) begin
      return {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      return {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction
`else
  localparam int SUM_W = ACC_W;

  // Wrapping build: the accumulator already is the result
  function automatic acc_t sat_acc(input logic signed [SUM_W-1:0] s);
    return s;
  endfunction
`endif

  state_t                   state_d, state_q;
  logic [IDX_W-1:0]         idx_d, idx_q;
  logic                     done_d, done_q;
  acc_t                     result_d, result_q;
  data_t                    a_in [N_ELEM];
  data_t                    b_in [N_ELEM];
  data_t                    a_reg_d [N_ELEM];
  data_t                    a_reg_q [N_ELEM];
  data_t                    b_reg_d [N_ELEM];
  data_t                    b_reg_q [N_ELEM];
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [SUM_W-1:0]  mac_acc;

  assign a_in = '{a0, a1, a2, a3, a4, a5, a6, a7};
  assign b_in = '{b0, b1, b2, b3, b4, b5, b6, b7};

  // FSM, index counter, operand capture and result publication
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = done_q;
    result_d = result_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_reg_d = a_in;
          b_reg_d = b_in;
          idx_d   = '0;
          done_d  = 1'b0;
          mac_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!idx_q[IDX_W-1]) begin
          // idx 0..7: one MAC per cycle
          mac_en = 1'b1;
          idx_d  = idx_q + 1'b1;
        end else begin
          // idx 8: all products summed, publish
          result_d = sat_acc(mac_acc);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Operand register file, loaded only when a start is accepted
  always_ff @(posedge clk) begin
    a_reg_q <= a_reg_d;
    b_reg_q <= b_reg_d;
  end

  dot_mac_unit #(
    .SUM_W (SUM_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_reg_q[idx_q[IDX_W-2:0]]),
    .b   (b_reg_q[idx_q[IDX_W-2:0]]),
    .acc (mac_acc)
  );

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_dot_product_accel.sv
// Bench for dot_product_accel: directed and random vectors, protocol and
// mid-run reset behaviour, checked against a plain-arithmetic model.
module tb_dot_product_accel;

  logic               clk;
  logic               rst;
  logic               start;
  logic               done;
  logic signed [31:0] a [8];
  logic signed [31:0] b [8];
  logic signed [63:0] result;

  int n_vec;
  int n_fail;
  logic signed [63:0] prev_result;

  dot_product_accel dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .done   (done),
    .a0 (a[0]), .a1 (a[1]), .a2 (a[2]), .a3 (a[3]),
    .a4 (a[4]), .a5 (a[5]), .a6 (a[6]), .a7 (a[7]),
    .b0 (b[0]), .b1 (b[1]), .b2 (b[2]), .b3 (b[3]),
    .b4 (b[4]), .b5 (b[5]), .b6 (b[6]), .b7 (b[7]),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Software dot product in 128-bit arithmetic, then wrapped or clamped
  function automatic logic signed [63:0] ref_dot();
    logic signed [127:0] s;
    longint ai, bi;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      ai = a[i];
      bi = b[i];
      s  = s + 128'(ai * bi);
    end
`ifdef DOT_SATURATE_EN
    if (s > 128'sh7FFF_FFFF_FFFF_FFFF) return 64'sh7FFF_FFFF_FFFF_FFFF;
    if (s < -128'sh8000_0000_0000_0000) return 64'sh8000_0000_0000_0000;
`endif
    return s[63:0];
  endfunction

  task automatic set_all(input logic signed [31:0] va, input logic signed [31:0] vb);
    for (int i = 0; i < 8; i++) begin
      a[i] = va;
      b[i] = vb;
    end
  endtask

  task automatic set_rand32();
    for (int i = 0; i < 8; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
  endtask

  task automatic set_rand16();
    logic signed [15:0] t;
    for (int i = 0; i < 8; i++) begin
      t = 16'($urandom);
      a[i] = 32'(t);
      t = 16'($urandom);
      b[i] = 32'(t);
    end
  endtask

  // Start a run on the current operands; optionally disturb inputs and
  // re-pulse start while it is in progress
  task automatic run(input string tag, input logic signed [63:0] exp,
                     input bit disturb);
    int cycles;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 4) check({tag, "_hold"}, result, prev_result);
      if (disturb) begin
        if (cycles == 1) set_rand32();
        if (cycles == 3) start = 1'b1;
        if (cycles == 4) start = 1'b0;
      end
    end
    check({tag, "_latency"}, 64'(cycles), 64'd9);
    check({tag, "_result"}, result, exp);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_stable"}, {63'd0, done} + result, 64'd1 + exp);
    prev_result = exp;
  endtask

  initial begin
    logic signed [63:0] exp;
    bit saw_done;
    n_vec = 0;
    n_fail = 0;
    prev_result = 0;
    rst = 1'b0;
    start = 1'b0;
    set_all(0, 0);

    repeat (3) @(negedge clk);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_done", {63'd0, done}, 64'd0);

    set_all(1, 1);
    run("all_ones", 64'sd8, 1'b0);

    for (int i = 0; i < 8; i++) begin
      a[i] = i + 1;
      b[i] = i + 1;
    end
    run("ramp", 64'sd204, 1'b0);

    set_all(-1, 5);
    run("sign", -64'sd40, 1'b0);

    set_all(32'sh7FFF_FFFF, 32'sh7FFF_FFFF);
`ifdef DOT_SATURATE_EN
    run("extreme", 64'sh7FFF_FFFF_FFFF_FFFF, 1'b0);
`else
    run("extreme", -64'sd34359738360, 1'b0);
`endif

    set_all(32'sh8000_0000, 32'sh8000_0000);
    run("extreme_min", ref_dot(), 1'b0);

    for (int k = 0; k < 2; k++) begin
      set_rand32();
      run("rand32", ref_dot(), 1'b0);
    end

    set_rand32();
    run("protocol", ref_dot(), 1'b1);

    for (int k = 0; k < 3; k++) begin
      set_rand16();
      run("b2b16", ref_dot(), 1'b0);
    end

    // Reset in the middle of a run
    set_rand32();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {63'd0, saw_done}, 64'd0);
    check("midrst_result_held", result, 64'd0);
    prev_result = 0;

    set_all(2, 2);
    run("after_reset", 64'sd32, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
